// File: rtl/sample_pack.sv
// Serial-to-parallel capture for two sample lanes, feeding a 2-entry word-pair FIFO
// with a valid/ready output and sticky overflow. Optional SAMPLE_PACK_PARITY_EN adds head parity.
module sample_pack #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             in_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [1:0]       fill_level,
    output logic             overflow,
`ifdef SAMPLE_PACK_PARITY_EN
    output logic             parity_a,
    output logic             parity_b,
`endif
    input  logic             clr_ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]    bitcnt;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [WIDTH-1:0] word_a, word_b;
    logic [WIDTH-1:0] mem_a [2];
    logic [WIDTH-1:0] mem_b [2];
    logic             rd_ptr, wr_ptr;
    logic [1:0]       count;
    logic             word_done, pop, push_ok, drop;

    assign word_a    = {a, sh_a[WIDTH-1:1]};
    assign word_b    = {b, sh_b[WIDTH-1:1]};
    assign word_done = in_valid && (bitcnt == CW'(WIDTH-1));
    assign pop       = (count != 2'd0) && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok   = word_done && ((count != 2'd2) || pop);
    assign drop      = word_done && !push_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt <= '0;
            sh_a   <= '0;
            sh_b   <= '0;
        end else if (in_valid) begin
            sh_a   <= word_a;
            sh_b   <= word_b;
            bitcnt <= word_done ? '0 : bitcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_a[wr_ptr] <= word_a;
                mem_b[wr_ptr] <= word_b;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_ok} - {1'b0, pop};
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    assign out_valid  = (count != 2'd0);
    assign fill_level = count;
    assign out_a      = out_valid ? mem_a[rd_ptr] : '0;
    assign out_b      = out_valid ? mem_b[rd_ptr] : '0;

`ifdef SAMPLE_PACK_PARITY_EN
    // Parity is captured alongside the word so the head never needs a reduction tree.
    logic mem_pa [2];
    logic mem_pb [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_pa[i] <= 1'b0;
                mem_pb[i] <= 1'b0;
            end
        end else if (push_ok) begin
            mem_pa[wr_ptr] <= ^word_a;
            mem_pb[wr_ptr] <= ^word_b;
        end
    end

    assign parity_a = out_valid ? mem_pa[rd_ptr] : 1'b0;
    assign parity_b = out_valid ? mem_pb[rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_sample_pack.sv
// Scoreboard bench for sample_pack (WIDTH=8): directed scenarios plus a random phase,
// each cycle compared against a queue-based reference of the packed word pairs.
module tb_sample_pack;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0, b = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
    logic       out_valid, overflow;
    logic [7:0] out_a, out_b;
    logic [1:0] fill_level;
`ifdef SAMPLE_PACK_PARITY_EN
    logic       parity_a, parity_b;
`endif

    sample_pack #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .in_valid   (in_valid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .fill_level (fill_level),
        .overflow   (overflow),
`ifdef SAMPLE_PACK_PARITY_EN
        .parity_a   (parity_a),
        .parity_b   (parity_b),
`endif
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_fail = 0;
    pair_t q[$];
    logic [7:0] m_sha, m_shb;
    int    m_cnt;
    logic  m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        pair_t h;
        h = (q.size() != 0) ? q[0] : '0;
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("fill_level", 32'(fill_level), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("out_a", 32'(out_a), 32'(h.a));
        check("out_b", 32'(out_b), 32'(h.b));
`ifdef SAMPLE_PACK_PARITY_EN
        check("parity_a", 32'(parity_a), 32'(^h.a));
        check("parity_b", 32'(parity_b), 32'(^h.b));
`endif
    endtask

    // One clock: drive inputs, compare at negedge, then advance the reference.
    task automatic step(input logic ia, input logic ib, input logic iv,
                        input logic ir, input logic ic);
        logic drop;
        a = ia; b = ib; in_valid = iv; out_ready = ir; clr_ovf = ic;
        @(negedge clk);
        check_outputs();
        drop = 1'b0;
        if (q.size() != 0 && ir)
            void'(q.pop_front());
        if (iv) begin
            m_sha = {ia, m_sha[7:1]};
            m_shb = {ib, m_shb[7:1]};
            if (m_cnt == 7) begin
                m_cnt = 0;
                if (q.size() < 2) q.push_back('{a: m_sha, b: m_shb});
                else drop = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (ic) m_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pack(input logic [7:0] wa, input logic [7:0] wb, input bit gap,
                        input logic rb, input logic rl, input logic cl);
        for (int i = 0; i < 8; i++) begin
            if (gap) step(1'b0, 1'b1, 1'b0, rb, 1'b0);
            step(wa[i], wb[i], 1'b1, (i == 7) ? rl : rb, (i == 7) ? cl : 1'b0);
        end
    endtask

    task automatic do_reset();
        a = 0; b = 0; in_valid = 0; out_ready = 0; clr_ovf = 0;
        rst_n = 1'b0;
        q.delete();
        m_cnt = 0; m_sha = '0; m_shb = '0; m_ovf = 1'b0;
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_out_a", 32'(out_a), 32'd0);
        check("rst_out_b", 32'(out_b), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Basic pack
        pack(8'h8D, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s1_valid", 32'(out_valid), 32'd1);
        check("s1_out_a", 32'(out_a), 32'h8D);
        check("s1_out_b", 32'(out_b), 32'hFF);
        check("s1_fill", 32'(fill_level), 32'd1);
`ifdef SAMPLE_PACK_PARITY_EN
        check("s1_par_a", 32'(parity_a), 32'd0);
        check("s1_par_b", 32'(parity_b), 32'd0);
`endif
        step(0, 0, 0, 1, 0);
        check("s1_drained", 32'(out_valid), 32'd0);

        // Gapped input
        pack(8'h8D, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        check("s2_out_a", 32'(out_a), 32'h8D);
        check("s2_out_b", 32'(out_b), 32'hFF);
        step(0, 0, 0, 1, 0);

        // Backpressure and overflow
        pack(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        pack(8'h33, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        pack(8'h55, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s3_fill", 32'(fill_level), 32'd2);
        check("s3_ovf", 32'(overflow), 32'd1);
        check("s3_head1", 32'(out_a), 32'h11);
        step(0, 0, 0, 1, 0);
        check("s3_head2", 32'(out_a), 32'h33);
        step(0, 0, 0, 1, 0);
        check("s3_empty", 32'(out_valid), 32'd0);
        step(0, 0, 0, 0, 1);
        check("s3_clr", 32'(overflow), 32'd0);

        // Full + pop + push
        pack(8'hA0, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0);
        pack(8'hA1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b0);
        pack(8'hA2, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b0);
        check("s4_ovf", 32'(overflow), 32'd0);
        check("s4_fill", 32'(fill_level), 32'd2);
        check("s4_head", 32'(out_a), 32'hA1);

        // Clear racing a drop
        pack(8'hC0, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("s5_race", 32'(overflow), 32'd1);
        step(0, 0, 0, 0, 1);
        check("s5_clr", 32'(overflow), 32'd0);
        step(0, 0, 0, 1, 0);
        check("s5_order", 32'(out_b), 32'hB2);
        step(0, 0, 0, 1, 0);

        // Reset mid-word and mid-handshake
        pack(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        pack(8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s6_out_a", 32'(out_a), 32'hFF);
        check("s6_out_b", 32'(out_b), 32'h5A);
        check("s6_ovf", 32'(overflow), 32'd0);
        check("s6_fill", 32'(fill_level), 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
